divider_8bit: RTL
=================

// Module: divider_8bit
// PURPOSE
//   Iterative restoring divider, the inverse of the ALU adder path: Q = A / B, R = A % B.
//   Uses one shared subtractor, one bit per clock, with a start/busy/done handshake.
//   Sits beside adder_8bit in the ALU and is launched by the CPU control unit.
// PARAMETERS
//   WIDTH  8  operand, quotient and remainder width in bits
// PORTS
//   clk       in   1      single system clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      launch request; sampled only in IDLE
//   A         in   WIDTH  dividend; captured on the edge that accepts start
//   B         in   WIDTH  divisor; captured on the edge that accepts start
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse; Q/R/flags are valid in this cycle
//   Q         out  WIDTH  quotient; held until the next accepted start
//   R         out  WIDTH  remainder; held until the next accepted start
//   DivZero   out  1      B was 0 for the last operation
//   Overflow  out  1      signed overflow (only -2^(W-1)/-1); always 0 unless DIV_SIGNED_EN
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, Q=0, R=0, DivZero=0, Overflow=0.
//     Applies at any cycle, including mid-RUN; the current operation is discarded.
//   States:
//     IDLE: start=1 and B!=0 -> RUN. Load rem=0, quo=A, cnt=WIDTH; clear the flags.
//     IDLE: start=1 and B==0 -> DONE. Q=all ones, R=A, DivZero=1.
//     RUN: each edge does {rem,quo} <<= 1, then diff = rem - B through the subtractor.
//       If no borrow: rem=diff and quo[0]=1. Otherwise: rem is kept and quo[0]=0.
//       cnt decrements every edge; when cnt reaches 0 -> DONE.
//     DONE: Q/R are driven and done=1 for exactly one cycle, then -> IDLE.
//   Latency, counted from the edge that accepts start:
//     Normal: done visible after edge WIDTH+1 (9 for WIDTH=8).
//     Divide-by-zero: done visible after edge 1.
//   Throughput: one operation per WIDTH+2 cycles. A new start is accepted in the cycle after done.
//   start while busy or during DONE is ignored. A and B may change freely during RUN.
//   Unsigned arithmetic; the remainder register is WIDTH+1 bits to hold the borrow.
//   Boundaries:
//     A < B gives Q=0, R=A.
//     A = 0 gives Q=0, R=0.
//     B = 1 gives Q=A, R=0.
// CONFIGURATION
//   DIV_SIGNED_EN defined:
//     Operands are two's complement. The magnitudes are divided.
//     Q is negated if sign(A)^sign(B). R takes the sign of A (truncation toward zero).
//     A=8'h80, B=8'hFF -> Q=8'h80, R=0, Overflow=1.
//     Divide-by-zero: Q=all ones, R=A.
//   DIV_SIGNED_EN undefined:
//     Unsigned only; Overflow is tied to 0; there is no sign logic.
// STRUCTURE
//   divider_defs.vh (shared include): state encodings DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2.
//     Also holds a counter-width macro DIV_CNT_W=4.
//   Sub-module subtractor_8bit (parameterised WIDTH+1): diff = X - Y with a borrow output.
//     It is the mirror of adder_8bit and is instantiated once.
// TESTING
//   1. A=200, B=7, start pulse -> done after 9 edges; Q=28, R=4, DivZero=0; busy high for 8 cycles.
//   2. A=55, B=0 -> done after 1 edge; Q=8'hFF, R=55, DivZero=1.
//   3. A=255, B=1 -> Q=255, R=0. Then A=3, B=10 -> Q=0, R=3.
//      Back-to-back starts, the second issued the cycle after done.
//   4. start A=100, B=9, re-pulse start (A=1, B=1) during RUN -> ignored; result Q=11, R=1.
//   5. rst asserted on RUN edge 4 -> next cycle all outputs 0 and IDLE.
//      A new start (A=9, B=3) then gives Q=3, R=0.
//   6. With DIV_SIGNED_EN:
//      A=-100 (8'h9C), B=7 -> Q=8'hF2 (-14), R=8'hFE (-2).
//      A=8'h80, B=8'hFF -> Q=8'h80, R=0, Overflow=1.

Source files
------------

// File: rtl/divider_8bit_pkg.sv
// Shared definitions for the iterative divider: state encodings and counter width.
package divider_8bit_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_CNT_W = 4;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_8bit_subtractor.sv
// Shared subtractor for the divider datapath: diff = x - y with a borrow-out.
module subtractor_8bit #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] full;

    assign full   = {1'b0, x} - {1'b0, y};
    assign diff   = full[WIDTH-1:0];
    assign borrow = full[WIDTH];

endmodule

// File: rtl/divider_8bit.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module divider_8bit
    import divider_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DivZero,
    output logic             Overflow
);

    localparam logic [WIDTH-1:0]     ZERO     = '0;
    localparam logic [WIDTH-1:0]     ALL_ONES = '1;
    localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

    div_state_t           state_q, state_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH:0]       shift_x, diff, rem_step;
    logic                 borrow;
    logic [WIDTH-1:0]     quo_step, a_mag, b_mag, q_fix, r_fix;
    logic                 accept_run, accept_zero, finish;

    assign accept_run  = (state_q == DIV_IDLE) && start && (B != ZERO);
    assign accept_zero = (state_q == DIV_IDLE) && start && (B == ZERO);
    assign finish      = (state_q == DIV_RUN) && (cnt_q == CNT_ONE);

    // Shift {rem,quo} left; rem top bit is always zero here, so the cast drops it.
    assign shift_x = (WIDTH+1)'({rem_q, quo_q[WIDTH-1]});

    subtractor_8bit #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .x      (shift_x),
        .y      ({1'b0, divisor_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign rem_step = borrow ? shift_x : diff;
    assign quo_step = {quo_q[WIDTH-2:0], ~borrow};

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;
    logic ovf_pend_q, ovf_pend_d;
    logic overflow_q, overflow_d;

    // Divide magnitudes, then restore signs (quotient by sign xor, remainder follows A).
    always_comb begin
        a_mag = A[WIDTH-1] ? ZERO - A : A;
        b_mag = B[WIDTH-1] ? ZERO - B : B;
        q_fix = neg_q_q ? ZERO - quo_step : quo_step;
        r_fix = neg_r_q ? ZERO - WIDTH'(rem_step) : WIDTH'(rem_step);
    end

    always_comb begin
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        if (accept_run || accept_zero) begin
            overflow_d = 1'b0;
        end
        if (accept_run) begin
            neg_q_d    = A[WIDTH-1] ^ B[WIDTH-1];
            neg_r_d    = A[WIDTH-1];
            ovf_pend_d = (A == MIN_NEG) && (B == ALL_ONES);
        end
        if (finish) begin
            overflow_d = ovf_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            ovf_pend_q <= ovf_pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign Overflow = overflow_q;
`else
    always_comb begin
        a_mag = A;
        b_mag = B;
        q_fix = quo_step;
        r_fix = WIDTH'(rem_step);
    end

    assign Overflow = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: begin
                if (accept_zero) begin
                    state_d = DIV_DONE;
                end else if (accept_run) begin
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (finish) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        busy_d      = (state_d == DIV_RUN);
        done_d      = (state_d == DIV_DONE);

        if (accept_zero) begin
            quotient_d  = ALL_ONES;
            remainder_d = A;
            div_zero_d  = 1'b1;
        end
        if (accept_run) begin
            rem_d      = '0;
            quo_d      = a_mag;
            divisor_d  = b_mag;
            cnt_d      = DIV_CNT_W'(WIDTH);
            div_zero_d = 1'b0;
        end
        if (state_q == DIV_RUN) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CNT_ONE;
        end
        if (finish) begin
            quotient_d  = q_fix;
            remainder_d = r_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Q       = quotient_q;
    assign R       = remainder_q;
    assign DivZero = div_zero_q;

endmodule
